i2s_sample_receiver: RTL and testbench

Front-end capture stage that sits directly upstream of the guitar effect's input sample path. It receives stereo audio from the codec ADC over I2S (BCLK, LRCK, ADCDAT), deserialises each channel word, sign-extends it to 32 bits and buffers it in a small FIFO. The effect input consumes the samples through a valid/ready handshake. Overflow and framing errors are reported through sticky flags that the Avalon status register reads.

---
 rtl/i2s_sample_receiver.sv | 175 +++++++++++++++++
 tb/tb_i2s_sample_receiver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_receiver.sv
// i2s_sample_receiver: captures stereo I2S words from the codec ADC,
// sign-extends each one to 32 bits and buffers it in a small FIFO.
//   clk            system clock, at least 4x the BCLK frequency
//   reset          asynchronous active-high reset
//   bclk/lrck/adcdat  asynchronous codec bit clock, word select, serial data
//   sample_data    head-of-FIFO sample (0 when empty)
//   sample_channel head-of-FIFO channel, 0 = left, 1 = right
//   sample_valid   FIFO not empty
//   sample_ready   consumer pops the head when high with sample_valid
//   overflow       sticky: a completed word was dropped on a full FIFO
//   frame_error    sticky: LRCK moved before a full word was captured
//   clear_flags    one-cycle pulse clearing both sticky flags
module i2s_sample_receiver #(
    parameter int DATA_W      = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bclk,
    input  logic        lrck,
    input  logic        adcdat,
    output logic [31:0] sample_data,
    output logic        sample_channel,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overflow,
    output logic        frame_error,
    input  logic        clear_flags
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, DRAIN} state_t;

    logic [SYNC_STAGES-1:0] r_bclk_sync, r_lrck_sync, r_dat_sync;
    logic                   r_bclk_prev, r_lr_last, r_lr_seen;
    logic                   w_bclk, w_lr, w_dat, w_strobe, w_lr_edge;

    state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]      r_shift, w_shift_nxt;
    logic                   r_chan, w_chan_nxt;
    logic                   w_done, w_ferr;

    logic                   r_push, r_push_chan;
    logic [31:0]            r_push_data, w_ext;

    logic [31:0]            r_mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  r_mem_chan;
    logic [PTR_W:0]         r_wptr, r_rptr;
    logic                   w_empty, w_full, w_pop, w_wr, w_drop;
    logic                   r_ovf, r_ferr;

    assign w_bclk    = r_bclk_sync[SYNC_STAGES-1];
    assign w_lr      = r_lrck_sync[SYNC_STAGES-1];
    assign w_dat     = r_dat_sync[SYNC_STAGES-1];
    assign w_strobe  = w_bclk & ~r_bclk_prev;
    // The first strobe after reset only records lrck, so a reset released
    // in the middle of a right slot is not mistaken for an LRCK edge.
    assign w_lr_edge = w_strobe & r_lr_seen & (w_lr != r_lr_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_prev <= 1'b0;
            r_lr_last   <= 1'b0;
            r_lr_seen   <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], bclk};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], lrck};
            r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], adcdat};
            r_bclk_prev <= w_bclk;
            if (w_strobe) begin
                r_lr_last <= w_lr;
                r_lr_seen <= 1'b1;
            end
        end
    end

    assign w_shift_nxt = {r_shift[DATA_W-2:0], w_dat};
    assign w_ext       = 32'($signed(w_shift_nxt));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_chan_nxt  = r_chan;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        if (w_strobe) begin
            if (r_state == SKIP) begin
                w_state_nxt = SHIFT;
                w_cnt_nxt   = '0;
            end
            if (r_state == SHIFT) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            // An edge that lands on the completing bit still pushes the
            // word (w_done above); only a genuinely short word is an error.
            if (w_lr_edge) begin
                w_chan_nxt  = w_lr;
                w_state_nxt = SKIP;
                w_ferr      = (r_state == SHIFT) && !w_done;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_chan      <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_push_chan <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chan  <= w_chan_nxt;
            r_push  <= w_done;
            if (w_strobe && r_state == SHIFT)
                r_shift <= w_shift_nxt;
            // The word carries the channel latched at its start, even when
            // the completing strobe is also the next LRCK edge.
            if (w_done) begin
                r_push_data <= w_ext;
                r_push_chan <= r_chan;
            end
        end
    end

    assign w_empty = r_wptr == r_rptr;
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_pop   = sample_valid & sample_ready;
    assign w_wr    = r_push & (~w_full | w_pop);
    assign w_drop  = r_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem_data[r_wptr[PTR_W-1:0]] <= r_push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_chan <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ovf      <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem_chan[r_wptr[PTR_W-1:0]] <= r_push_chan;
                r_wptr <= r_wptr + (PTR_W+1)'(1);
            end
            if (w_pop)
                r_rptr <= r_rptr + (PTR_W+1)'(1);
            r_ovf  <= w_drop | (r_ovf & ~clear_flags);
            r_ferr <= w_ferr | (r_ferr & ~clear_flags);
        end
    end

    assign sample_valid   = ~w_empty;
    assign sample_data    = w_empty ? 32'd0 : r_mem_data[r_rptr[PTR_W-1:0]];
    assign sample_channel = ~w_empty & r_mem_chan[r_rptr[PTR_W-1:0]];
    assign overflow       = r_ovf;
    assign frame_error    = r_ferr;
endmodule

// File: tb/tb_i2s_sample_receiver.sv
// tb_i2s_sample_receiver: directed I2S frames with a queue scoreboard and
// an independent monitor that checks every popped sample.
module tb_i2s_sample_receiver;
    logic        clk = 1'b0, reset = 1'b1, bclk = 1'b0, lrck = 1'b0, adcdat = 1'b0;
    logic        sample_ready = 1'b0, clear_flags = 1'b0;
    logic [31:0] sample_data;
    logic        sample_channel, sample_valid, overflow, frame_error;

    int checks = 0, errors = 0, cyc = 0, pop_cyc = -1;
    bit rdy_mode = 1'b0, arm_pop = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic        c;
        int          cy;
    } exp_t;
    exp_t sb[$];
    exp_t pend, mon_e;
    bit   pend_v = 1'b0;

    i2s_sample_receiver #(.DATA_W(24), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bclk(bclk), .lrck(lrck), .adcdat(adcdat),
        .sample_data(sample_data), .sample_channel(sample_channel),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overflow(overflow), .frame_error(frame_error), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Ready is high in rdy_mode, or for the single cycle pop_cyc.
    initial forever begin
        tick();
        sample_ready = rdy_mode | (cyc == pop_cyc);
    end

    always @(negedge clk) begin
        if (!reset && sample_valid && sample_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got %h expected none", sample_data);
            end else begin
                mon_e = sb.pop_front();
                chk("sample_data", sample_data, mon_e.d);
                chk("sample_channel", 32'(sample_channel), 32'(mon_e.c));
                if (mon_e.cy != 0) chk("valid_latency_cycle", cyc, mon_e.cy);
            end
        end
    end

    // One I2S slot: bit k=0 is the LRCK edge strobe, k=1 the skip bit,
    // k=2..25 carry the 24-bit word MSB first. d0 feeds bit 0.
    task automatic send_slot(input logic lr, input logic [23:0] w, input int k0, input int len,
                             input logic d0, input bit push, input logic [31:0] exp_d);
        exp_t e;
        for (int k = k0; k < len; k++) begin
            bclk   = 1'b0;
            lrck   = lr;
            adcdat = (k == 0) ? d0 : (k >= 2 && k <= 25) ? w[25-k] : 1'b0;
            repeat (4) tick();
            bclk = 1'b1;
            if (k == 0 && pend_v) begin
                pend.cy = rdy_mode ? cyc + 4 : 0;
                sb.push_back(pend);
                pend_v = 1'b0;
            end
            if (k == 25 && push) begin
                e.d  = exp_d;
                e.c  = lr;
                e.cy = rdy_mode ? cyc + 4 : 0;
                sb.push_back(e);
                if (arm_pop) pop_cyc = cyc + 3;
            end
            repeat (4) tick();
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) tick();
        chk("valid_after_drain", 32'(sample_valid), 32'd0);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_valid", 32'(sample_valid), 32'd0);
        chk("reset_data", sample_data, 32'd0);
        chk("reset_channel", 32'(sample_channel), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_frame_error", 32'(frame_error), 32'd0);
        reset = 1'b0;
        tick();

        // Start mid left word, then full words with exact latency.
        rdy_mode = 1'b1;
        send_slot(1'b0, 24'h000000, 10, 32, 1'b0, 1'b0, 32'h0);
        send_slot(1'b1, 24'h123456, 0, 32, 1'b0, 1'b1, 32'h00123456);
        send_slot(1'b0, 24'h7FFFFF, 0, 32, 1'b0, 1'b1, 32'h007FFFFF);
        send_slot(1'b1, 24'h800001, 0, 32, 1'b0, 1'b1, 32'hFF800001);
        drain();
        chk("midword_frame_error", 32'(frame_error), 32'd0);
        chk("midword_overflow", 32'(overflow), 32'd0);

        // Six words into a four-entry FIFO with ready low.
        rdy_mode = 1'b0;
        send_slot(1'b0, 24'h000001, 0, 32, 1'b0, 1'b1, 32'h00000001);
        send_slot(1'b1, 24'hFFFFFE, 0, 32, 1'b0, 1'b1, 32'hFFFFFFFE);
        send_slot(1'b0, 24'h555555, 0, 32, 1'b0, 1'b1, 32'h00555555);
        send_slot(1'b1, 24'hAAAAAA, 0, 32, 1'b0, 1'b1, 32'hFFAAAAAA);
        send_slot(1'b0, 24'h0F0F0F, 0, 32, 1'b0, 1'b0, 32'h0);
        send_slot(1'b1, 24'hF0F0F0, 0, 32, 1'b0, 1'b0, 32'h0);
        chk("overflow_set", 32'(overflow), 32'd1);
        chk("full_head_data", sample_data, 32'h00000001);
        chk("full_head_channel", 32'(sample_channel), 32'd0);
        pulse_clear();
        chk("overflow_cleared", 32'(overflow), 32'd0);

        // Push into a full FIFO in the same cycle as a pop.
        arm_pop = 1'b1;
        send_slot(1'b0, 24'h13579B, 0, 32, 1'b0, 1'b1, 32'h0013579B);
        arm_pop = 1'b0;
        pop_cyc = -1;
        chk("pushpop_overflow", 32'(overflow), 32'd0);
        chk("pushpop_valid", 32'(sample_valid), 32'd1);
        chk("pushpop_head_data", sample_data, 32'hFFFFFFFE);
        chk("pushpop_head_channel", 32'(sample_channel), 32'd1);
        rdy_mode = 1'b1;
        drain();
        chk("empty_data_zero", sample_data, 32'd0);

        // LRCK toggles after 10 of 24 bits.
        send_slot(1'b1, 24'hFFFFFF, 0, 12, 1'b0, 1'b0, 32'h0);
        send_slot(1'b0, 24'h3C3C3C, 0, 32, 1'b0, 1'b1, 32'h003C3C3C);
        drain();
        chk("frame_error_set", 32'(frame_error), 32'd1);
        pulse_clear();
        chk("frame_error_cleared", 32'(frame_error), 32'd0);

        // LRCK edge on the strobe that carries the last bit.
        send_slot(1'b1, 24'h654321, 0, 25, 1'b0, 1'b0, 32'h0);
        pend.d = 32'h00654321;
        pend.c = 1'b1;
        pend_v = 1'b1;
        send_slot(1'b0, 24'h89ABCD, 0, 32, 1'b1, 1'b1, 32'hFF89ABCD);
        drain();
        chk("coincident_frame_error", 32'(frame_error), 32'd0);

        // Reset with two buffered words and a capture mid-shift.
        rdy_mode = 1'b0;
        send_slot(1'b1, 24'h000000, 0, 12, 1'b0, 1'b0, 32'h0);
        send_slot(1'b0, 24'h111111, 0, 32, 1'b0, 1'b1, 32'h00111111);
        send_slot(1'b1, 24'h222222, 0, 32, 1'b0, 1'b1, 32'h00222222);
        send_slot(1'b0, 24'h5A5A5A, 0, 12, 1'b0, 1'b0, 32'h0);
        chk("prereset_frame_error", 32'(frame_error), 32'd1);
        chk("prereset_valid", 32'(sample_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("midreset_valid", 32'(sample_valid), 32'd0);
        chk("midreset_data", sample_data, 32'd0);
        chk("midreset_overflow", 32'(overflow), 32'd0);
        chk("midreset_frame_error", 32'(frame_error), 32'd0);
        sb.delete();
        repeat (3) tick();
        reset = 1'b0;
        rdy_mode = 1'b1;
        send_slot(1'b0, 24'h5A5A5A, 12, 32, 1'b0, 1'b0, 32'h0);
        send_slot(1'b1, 24'h7ABCDE, 0, 32, 1'b0, 1'b1, 32'h007ABCDE);
        drain();
        chk("final_frame_error", 32'(frame_error), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
